// File: rtl/wbu.sv
// Writeback unit: two-deep in-order retirement buffer feeding the register file,
// with a per-register pending-write scoreboard and a sticky overflow flag.
module wbu #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exe_valid_i,
  output logic            exe_ready_o,
  input  logic            exe_wen_i,
  input  logic [4:0]      exe_rd_i,
  input  logic [XLEN-1:0] exe_res_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic            id_set_i,
  input  logic [4:0]      id_rd_i,
  input  logic            wb_stall_i,
  output logic            rf_wen_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            commit_valid_o,
  output logic [XLEN-1:0] commit_pc_o,
  output logic [NREG-1:0] busy_o,
  output logic            ovf_o
);

  logic [1:0]      count_reg;
  logic            wr_ptr_reg;
  logic            rd_ptr_reg;
  logic [1:0]      wen_mem;
  logic [4:0]      rd_mem  [2];
  logic [XLEN-1:0] res_mem [2];
  logic [XLEN-1:0] pc_mem  [2];
  logic            ovf_reg;
  logic [NREG-1:0] sat_hit;

  logic            accept;
  logic            retire;
  logic            head_wen;
  logic [4:0]      head_rd;

  // Ready looks only at registered occupancy so it never waits on this cycle's retirement.
  assign exe_ready_o = rst_n && (count_reg < 2'd2);
  assign accept      = exe_valid_i && exe_ready_o;
  assign retire      = rst_n && (count_reg != 2'd0) && !wb_stall_i;

  assign head_wen = wen_mem[rd_ptr_reg];
  assign head_rd  = rd_mem[rd_ptr_reg];

  assign commit_valid_o = retire;
  assign rf_wen_o       = retire && head_wen && (head_rd != 5'd0);
  assign rf_waddr_o     = retire ? head_rd : 5'd0;
  assign rf_wdata_o     = retire ? res_mem[rd_ptr_reg] : '0;
  assign commit_pc_o    = retire ? pc_mem[rd_ptr_reg] : '0;
  assign ovf_o          = ovf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (retire) rd_ptr_reg <= ~rd_ptr_reg;
      case ({accept, retire})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_mem[wr_ptr_reg] <= exe_wen_i;
      rd_mem[wr_ptr_reg]  <= exe_rd_i;
      res_mem[wr_ptr_reg] <= exe_res_i;
      pc_mem[wr_ptr_reg]  <= exe_pc_i;
    end
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      logic [1:0] cnt_reg;
      logic       inc;
      logic       dec;

      assign inc         = id_set_i && (id_rd_i != 5'd0) && (id_rd_i == 5'(gi));
      assign dec         = rf_wen_o && (head_rd == 5'(gi));
      assign sat_hit[gi] = inc && !dec && (cnt_reg == 2'd3);

      // A matched set/clear pair cancels; a set on a saturated counter is dropped.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= 2'd0;
        end else if (inc && !dec && (cnt_reg != 2'd3)) begin
          cnt_reg <= cnt_reg + 2'd1;
        end else if (dec && !inc && (cnt_reg != 2'd0)) begin
          cnt_reg <= cnt_reg - 2'd1;
        end
      end

      if (gi == 0) begin : g_zero
        assign busy_o[gi] = 1'b0;
      end else begin : g_reg
        assign busy_o[gi] = rst_n && (cnt_reg != 2'd0);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (|sat_hit) begin
      ovf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: directed vector table for the documented scenarios, then
// randomized traffic compared against a queue/counter reference model.
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_valid_i;
  logic        exe_ready_o;
  logic        exe_wen_i;
  logic [4:0]  exe_rd_i;
  logic [31:0] exe_res_i;
  logic [31:0] exe_pc_i;
  logic        id_set_i;
  logic [4:0]  id_rd_i;
  logic        wb_stall_i;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        commit_valid_o;
  logic [31:0] commit_pc_o;
  logic [31:0] busy_o;
  logic        ovf_o;

  wbu #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .exe_valid_i(exe_valid_i), .exe_ready_o(exe_ready_o),
    .exe_wen_i(exe_wen_i), .exe_rd_i(exe_rd_i),
    .exe_res_i(exe_res_i), .exe_pc_i(exe_pc_i),
    .id_set_i(id_set_i), .id_rd_i(id_rd_i), .wb_stall_i(wb_stall_i),
    .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rst_n, valid, wen;
    bit [4:0]  rd;
    bit [31:0] res, pc;
    bit        id_set;
    bit [4:0]  id_rd;
    bit        stall;
    bit        e_rdy, e_wen, e_cv;
    bit [4:0]  e_waddr;
    bit [31:0] e_wdata, e_cpc, e_busy;
    bit        e_ovf;
  } vec_t;

  typedef struct {
    bit        wen;
    bit [4:0]  rd;
    bit [31:0] res, pc;
  } ent_t;

  int tests = 0;
  int fails = 0;
  int cyc_no = 0;

  // Reference model state
  ent_t m_q[$];
  int   m_cnt[32];
  bit   m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL cycle %0d %s: got 0x%0h expected 0x%0h", cyc_no, name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit v, bit w, int rd, bit [31:0] res, bit [31:0] pc,
                              bit ids, int idrd, bit st, bit erdy, bit ew, bit ecv, int ewa,
                              bit [31:0] ewd, bit [31:0] ecpc, bit [31:0] ebusy, bit eovf);
    vec_t t;
    t.rst_n = r; t.valid = v; t.wen = w; t.rd = 5'(rd); t.res = res; t.pc = pc;
    t.id_set = ids; t.id_rd = 5'(idrd); t.stall = st;
    t.e_rdy = erdy; t.e_wen = ew; t.e_cv = ecv; t.e_waddr = 5'(ewa);
    t.e_wdata = ewd; t.e_cpc = ecpc; t.e_busy = ebusy; t.e_ovf = eovf;
    return t;
  endfunction

  // Model's view of the outputs for the current cycle, from the queue and counters.
  function automatic vec_t model_exp(vec_t v);
    vec_t e = v;
    bit ret = v.rst_n && (m_q.size() > 0) && !v.stall;
    e.e_rdy = v.rst_n && (m_q.size() < 2);
    e.e_cv = ret;
    e.e_wen = ret && m_q[0].wen && (m_q[0].rd != 0);
    e.e_waddr = ret ? m_q[0].rd : 5'd0;
    e.e_wdata = ret ? m_q[0].res : 32'd0;
    e.e_cpc = ret ? m_q[0].pc : 32'd0;
    e.e_busy = 32'd0;
    for (int r = 1; r < 32; r++) e.e_busy[r] = v.rst_n && (m_cnt[r] != 0);
    e.e_ovf = m_ovf;
    return e;
  endfunction

  task automatic model_step(vec_t v);
    if (!v.rst_n) begin
      m_q.delete();
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_ovf = 0;
    end else begin
      bit ret = (m_q.size() > 0) && !v.stall;
      bit acc = v.valid && (m_q.size() < 2);
      int dr = -1;
      int ir = (v.id_set && v.id_rd != 0) ? int'(v.id_rd) : -1;
      ent_t n;
      if (ret && m_q[0].wen && m_q[0].rd != 0) dr = m_q[0].rd;
      if (ret) void'(m_q.pop_front());
      n.wen = v.wen; n.rd = v.rd; n.res = v.res; n.pc = v.pc;
      if (acc) m_q.push_back(n);
      for (int r = 0; r < 32; r++) begin
        int net = (r == ir ? 1 : 0) - (r == dr ? 1 : 0);
        if (net > 0) begin
          if (m_cnt[r] == 3) m_ovf = 1;
          else m_cnt[r]++;
        end else if (net < 0 && m_cnt[r] > 0) begin
          m_cnt[r]--;
        end
      end
    end
  endtask

  // Drive one cycle, check outputs mid-cycle, advance the model, then step the clock.
  task automatic cycle(vec_t v, bit use_table);
    vec_t e;
    rst_n = v.rst_n; exe_valid_i = v.valid; exe_wen_i = v.wen; exe_rd_i = v.rd;
    exe_res_i = v.res; exe_pc_i = v.pc; id_set_i = v.id_set; id_rd_i = v.id_rd;
    wb_stall_i = v.stall;
    #2;
    e = use_table ? v : model_exp(v);
    chk("exe_ready", 64'(exe_ready_o), 64'(e.e_rdy));
    chk("commit_valid", 64'(commit_valid_o), 64'(e.e_cv));
    chk("rf_wen", 64'(rf_wen_o), 64'(e.e_wen));
    chk("rf_waddr", 64'(rf_waddr_o), 64'(e.e_waddr));
    chk("rf_wdata", 64'(rf_wdata_o), 64'(e.e_wdata));
    chk("commit_pc", 64'(commit_pc_o), 64'(e.e_cpc));
    chk("busy", 64'(busy_o), 64'(e.e_busy));
    chk("ovf", 64'(ovf_o), 64'(e.e_ovf));
    model_step(v);
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  vec_t tab[$];
  localparam bit [31:0] B5 = 32'h0000_0020;
  localparam bit [31:0] B7 = 32'h0000_0080;
  localparam bit [31:0] B9 = 32'h0000_0200;

  initial begin
    vec_t rv;
    rst_n = 1'b0; exe_valid_i = 1'b0; exe_wen_i = 1'b0; exe_rd_i = 5'd0;
    exe_res_i = 32'd0; exe_pc_i = 32'd0; id_set_i = 1'b0; id_rd_i = 5'd0; wb_stall_i = 1'b0;
    m_ovf = 0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;

    // rst v w rd res pc ids idrd st | rdy wen cv waddr wdata cpc busy ovf
    tab.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    // single write to x5
    tab.push_back(mk(1,0,0,0,0,0,1,5,0, 1,0,0,0,0,0,0,0));
    tab.push_back(mk(1,1,1,5,32'hDEADBEEF,32'h80000000,0,0,0, 1,0,0,0,0,0,B5,0));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,1,5,32'hDEADBEEF,32'h80000000,B5,0));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));
    // x0: commits without a register write; id_set on x0 is ignored
    tab.push_back(mk(1,1,1,0,32'h11,32'h100,1,0,0, 1,0,0,0,0,0,0,0));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,1,0,32'h11,32'h100,0,0));
    // backpressure: third result refused, then ordered drain
    tab.push_back(mk(1,1,1,3,32'hA,32'h200,0,0,1, 1,0,0,0,0,0,0,0));
    tab.push_back(mk(1,1,1,4,32'hB,32'h204,0,0,1, 1,0,0,0,0,0,0,0));
    tab.push_back(mk(1,1,1,6,32'hC,32'h208,0,0,1, 0,0,0,0,0,0,0,0));
    tab.push_back(mk(1,1,1,6,32'hC,32'h208,0,0,0, 0,1,1,3,32'hA,32'h200,0,0));
    tab.push_back(mk(1,1,1,6,32'hC,32'h208,0,0,0, 1,1,1,4,32'hB,32'h204,0,0));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,1,6,32'hC,32'h208,0,0));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));
    // scoreboard saturation on x7, then set+retire in one cycle keeps it at 3
    tab.push_back(mk(1,0,0,0,0,0,1,7,0, 1,0,0,0,0,0,0,0));
    tab.push_back(mk(1,0,0,0,0,0,1,7,0, 1,0,0,0,0,0,B7,0));
    tab.push_back(mk(1,0,0,0,0,0,1,7,0, 1,0,0,0,0,0,B7,0));
    tab.push_back(mk(1,0,0,0,0,0,1,7,0, 1,0,0,0,0,0,B7,0));
    tab.push_back(mk(1,1,1,7,32'h77,32'h300,0,0,0, 1,0,0,0,0,0,B7,1));
    tab.push_back(mk(1,0,0,0,0,0,1,7,0, 1,1,1,7,32'h77,32'h300,B7,1));
    tab.push_back(mk(1,1,1,7,32'h1,32'h310,0,0,0, 1,0,0,0,0,0,B7,1));
    tab.push_back(mk(1,1,1,7,32'h2,32'h314,0,0,0, 1,1,1,7,32'h1,32'h310,B7,1));
    tab.push_back(mk(1,1,1,7,32'h3,32'h318,0,0,0, 1,1,1,7,32'h2,32'h314,B7,1));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,1,7,32'h3,32'h318,B7,1));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,1));
    // reset with a full buffer: nothing retires, everything clears
    tab.push_back(mk(1,1,1,9,32'h90,32'h400,1,9,1, 1,0,0,0,0,0,0,1));
    tab.push_back(mk(1,1,1,10,32'hA0,32'h404,0,0,1, 1,0,0,0,0,0,B9,1));
    tab.push_back(mk(0,1,1,11,32'hB0,32'h408,0,0,0, 0,0,0,0,0,0,0,1));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));
    tab.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tab.size(); i++) cycle(tab[i], 1'b1);

    for (int i = 0; i < 2000; i++) begin
      rv = mk(($urandom_range(63) != 0), ($urandom_range(3) != 0), ($urandom_range(4) != 0),
              int'($urandom_range(7)), $urandom, $urandom, ($urandom_range(2) == 0),
              int'($urandom_range(7)), ($urandom_range(2) == 0), 0,0,0,0,0,0,0,0);
      cycle(rv, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath width of result and PC.
REQ-002 Parameter NREG, default 32, SHALL set the architectural register count; register index width SHALL be 5.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 Port exe_valid_i  input  1  SHALL mark a valid EXE result.
REQ-006 Port exe_ready_o  output  1  SHALL mark that the block can accept an EXE result.
REQ-007 Port exe_wen_i  input  1  SHALL mark that the result writes a register.
REQ-008 Port exe_rd_i  input  5  SHALL carry the destination register index.
REQ-009 Port exe_res_i  input  XLEN  SHALL carry the EXE result.
REQ-010 Port exe_pc_i  input  XLEN  SHALL carry the PC of the instruction.
REQ-011 Port id_set_i  input  1  SHALL mark issue of a register-writing instruction.
REQ-012 Port id_rd_i  input  5  SHALL carry the destination index of the issuing instruction.
REQ-013 Port wb_stall_i  input  1  SHALL block retirement for the current cycle.
REQ-014 Port rf_wen_o  output  1  SHALL be the register-file write enable.
REQ-015 Port rf_waddr_o  output  5  SHALL be the register-file write index.
REQ-016 Port rf_wdata_o  output  XLEN  SHALL be the register-file write data.
REQ-017 Port commit_valid_o  output  1  SHALL pulse once per retired instruction.
REQ-018 Port commit_pc_o  output  XLEN  SHALL carry the PC of the retiring instruction.
REQ-019 Port busy_o  output  NREG  SHALL flag registers with pending writes.
REQ-020 Port ovf_o  output  1  SHALL be a sticky scoreboard-overflow flag.

Function
REQ-021 The block SHALL hold a 2-entry in-order FIFO of {wen, rd, res, pc}.
REQ-022 exe_ready_o SHALL be 1 iff the registered occupancy is below 2; it SHALL NOT depend on same-cycle retirement.
REQ-023 The block SHALL accept an entry iff exe_valid_i and exe_ready_o are both 1.
REQ-024 An accepted entry SHALL become retirable no earlier than the next cycle (minimum latency 1).
REQ-025 The head entry SHALL retire combinationally in any cycle where occupancy > 0 and wb_stall_i = 0.
REQ-026 On retirement, commit_valid_o SHALL be 1 and commit_pc_o SHALL equal the head pc.
REQ-027 On retirement, rf_wen_o SHALL be head.wen AND (head.rd != 0).
REQ-028 rf_waddr_o and rf_wdata_o SHALL equal head.rd and head.res.
REQ-029 When no retirement occurs, rf_wen_o and commit_valid_o SHALL be 0.
REQ-030 A simultaneous accept and retire SHALL leave occupancy unchanged and preserve order.
REQ-031 FIFO pointers SHALL wrap modulo 2.
REQ-032 The scoreboard SHALL keep a 2-bit counter per register.
REQ-033 id_set_i with id_rd_i != 0 SHALL increment the counter for id_rd_i.
REQ-034 A retirement with rf_wen_o = 1 SHALL decrement the counter for head.rd.
REQ-035 An increment and a decrement on the same register in the same cycle SHALL leave that counter unchanged.
REQ-036 An increment of a counter already at 3 SHALL be dropped and SHALL set ovf_o, which holds until reset.
REQ-037 busy_o[i] SHALL be (counter[i] != 0); busy_o[0] SHALL always be 0.
REQ-038 A retirement with wen = 1 and rd = 0, or with wen = 0, SHALL NOT change any counter.

Reset
REQ-039 While rst_n = 0 at a clock edge, occupancy, pointers, all counters and ovf_o SHALL be cleared to 0.
REQ-040 During reset, exe_ready_o, rf_wen_o, commit_valid_o, busy_o, rf_waddr_o, rf_wdata_o and commit_pc_o SHALL be 0.
REQ-041 A reset mid-operation SHALL discard buffered entries without retiring them; no accept SHALL occur in a reset cycle.

Verification
REQ-042 Single write: id_set rd=5; next cycle, accept {wen=1, rd=5, res=0xDEADBEEF, pc=0x80000000} -> busy_o[5]=1, then next cycle rf_wen_o=1, waddr=5, wdata=0xDEADBEEF, commit_pc=0x80000000, then busy_o[5]=0.
REQ-043 Backpressure: wb_stall_i=1 with 3 back-to-back valid results -> exe_ready_o=0 after 2 accepts; release stall -> retirements occur in order on consecutive cycles.
REQ-044 x0: accept {wen=1, rd=0} -> commit_valid_o=1, rf_wen_o=0; id_set rd=0 -> busy_o unchanged.
REQ-045 Scoreboard: 4 id_set rd=7 without retirement -> counter=3, ovf_o=1; same-cycle set and retire on rd=7 -> counter unchanged.
REQ-046 Reset mid-run: FIFO full, rst_n=0 for 1 cycle -> no commit pulse, occupancy 0, busy_o=0, exe_ready_o=1 the cycle after release.
